// File: rtl/sram_req_master.sv
// 64-bit load/store front end for a 32-bit single-port SRAM: each request becomes up to two
// word beats (low word first), read words are reassembled and returned on a response channel.
module sram_req_master #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-2:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic [ADDR_W-1:0] io_adr,
  output logic              io_cen,
  output logic              io_wen,
  output logic [3:0]        io_wstrb,
  output logic [31:0]       io_d,
  input  logic [31:0]       io_q,
  output logic [2:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid is never withdrawn and its payload is held until that edge.
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic              cen;
    logic              wen;
    logic [3:0]        wstrb;
    logic [31:0]       d;
  } pins_t;

  localparam pins_t PINS_IDLE = '{adr: '0, cen: 1'b1, wen: 1'b1, wstrb: 4'h0, d: 32'h0};

  function automatic pins_t beat_pins(input logic hi, input logic wr,
                                      input logic [ADDR_W-2:0] idx,
                                      input logic [63:0] wdata, input logic [7:0] wstrb);
    pins_t p;
    p.adr   = {idx, hi};
    p.cen   = 1'b0;
    p.wen   = ~wr;
    p.wstrb = wr ? (hi ? wstrb[7:4] : wstrb[3:0]) : 4'h0;
    p.d     = wr ? (hi ? wdata[63:32] : wdata[31:0]) : 32'h0;
    return p;
  endfunction

  state_t            r_state;
  logic              r_wen;
  logic [ADDR_W-2:0] r_idx;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;
  pins_t             r_pins;
  logic [2:0]        r_wcnt;
  logic [63:0]       r_rdata;
  logic              r_resp_valid;
  logic              r_req_ready;
  logic [1:0]        r_tag [READ_LAT];

  logic w_issue_rd;
  logic w_issue_hi;

  assign w_issue_rd = ((r_state == S_LO) || (r_state == S_HI)) && !r_wen;
  assign w_issue_hi = (r_state == S_HI);

  // Tag {valid, beat} travels alongside each read so it emerges in the cycle io_q is valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LAT; i++) r_tag[i] <= 2'b00;
    end else begin
      r_tag[0] <= {w_issue_rd, w_issue_hi};
      for (int i = 1; i < READ_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wen        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= 64'h0;
      r_wstrb      <= 8'h0;
      r_pins       <= PINS_IDLE;
      r_wcnt       <= 3'h0;
      r_rdata      <= 64'h0;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wen       <= req_wen;
            r_idx       <= req_addr;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_rdata     <= 64'h0;
            r_req_ready <= 1'b0;
            if (!req_wen || (req_wstrb[3:0] != 4'h0)) begin
              r_state <= S_LO;
              r_pins  <= beat_pins(1'b0, req_wen, req_addr, req_wdata, req_wstrb);
            end else if (req_wstrb[7:4] != 4'h0) begin
              r_state <= S_HI;
              r_pins  <= beat_pins(1'b1, req_wen, req_addr, req_wdata, req_wstrb);
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (!r_wen || (r_wstrb[7:4] != 4'h0)) begin
            r_state <= S_HI;
            r_pins  <= beat_pins(1'b1, r_wen, r_idx, r_wdata, r_wstrb);
          end else begin
            r_state      <= S_RESP;
            r_pins       <= PINS_IDLE;
            r_resp_valid <= 1'b1;
          end
        end
        S_HI: begin
          r_pins <= PINS_IDLE;
          if (!r_wen) begin
            r_state <= S_WAIT;
            r_wcnt  <= 3'(READ_LAT - 1);
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_wcnt == 3'h0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - 3'h1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_pins       <= PINS_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase

      // Tags are only live between LO and the last WAIT cycle, never alongside an accept.
      if (r_tag[READ_LAT-1][1]) begin
        if (r_tag[READ_LAT-1][0]) r_rdata[63:32] <= io_q;
        else                      r_rdata[31:0]  <= io_q;
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_rdata;
  assign io_adr      = r_pins.adr;
  assign io_cen      = r_pins.cen;
  assign io_wen      = r_pins.wen;
  assign io_wstrb    = r_pins.wstrb;
  assign io_d        = r_pins.d;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_req_master.sv
// Bench for sram_req_master: directed and random requests against a word-array reference,
// with a second instance at READ_LAT = 3 for the long-latency read path.
module tb_sram_req_master;

  localparam int RL1 = 1;
  localparam int RL3 = 3;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // instance at READ_LAT = 1
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic [7:0]  io_adr;
  logic        io_cen, io_wen;
  logic [3:0]  io_wstrb;
  logic [31:0] io_d, io_q;
  logic [2:0]  dbg_state;

  sram_req_master #(.ADDR_W(8), .READ_LAT(RL1)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .io_adr(io_adr), .io_cen(io_cen), .io_wen(io_wen), .io_wstrb(io_wstrb),
    .io_d(io_d), .io_q(io_q), .o_dbg_state(dbg_state)
  );

  // instance at READ_LAT = 3
  logic        d3_req_valid = 1'b0, d3_req_ready, d3_req_wen = 1'b0;
  logic [6:0]  d3_req_addr = '0;
  logic [63:0] d3_req_wdata = '0;
  logic [7:0]  d3_req_wstrb = '0;
  logic        d3_resp_valid, d3_resp_ready = 1'b0;
  logic [63:0] d3_resp_rdata;
  logic [7:0]  d3_io_adr;
  logic        d3_io_cen, d3_io_wen;
  logic [3:0]  d3_io_wstrb;
  logic [31:0] d3_io_d, d3_io_q;
  logic [2:0]  d3_dbg_state;

  sram_req_master #(.ADDR_W(8), .READ_LAT(RL3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_wen(d3_req_wen),
    .req_addr(d3_req_addr), .req_wdata(d3_req_wdata), .req_wstrb(d3_req_wstrb),
    .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready), .resp_rdata(d3_resp_rdata),
    .io_adr(d3_io_adr), .io_cen(d3_io_cen), .io_wen(d3_io_wen), .io_wstrb(d3_io_wstrb),
    .io_d(d3_io_d), .io_q(d3_io_q), .o_dbg_state(d3_dbg_state)
  );

  // SRAM models: byte-strobed writes, reads delivered READ_LAT cycles after issue
  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] mem1 [256];
  logic [31:0] rd1 [RL1];
  bit          pre1 = 1'b0;
  assign io_q = rd1[RL1-1];
  always @(posedge clock) begin
    if (!pre1) begin
      for (int i = 0; i < 256; i++) mem1[i] = init_word(i);
      pre1 = 1'b1;
    end
    rd1[0] <= 32'hDEAD_BEEF;
    if (!io_cen) begin
      if (!io_wen) begin
        for (int b = 0; b < 4; b++) if (io_wstrb[b]) mem1[io_adr][8*b +: 8] = io_d[8*b +: 8];
      end else begin
        rd1[0] <= mem1[io_adr];
      end
    end
  end

  logic [31:0] mem3 [256];
  logic [31:0] rd3 [RL3];
  bit          pre3 = 1'b0;
  assign d3_io_q = rd3[RL3-1];
  always @(posedge clock) begin
    if (!pre3) begin
      for (int i = 0; i < 256; i++) mem3[i] = 32'(i);
      pre3 = 1'b1;
    end
    rd3[0] <= 32'hDEAD_BEEF;
    if (!d3_io_cen && d3_io_wen) rd3[0] <= mem3[d3_io_adr];
    for (int i = 1; i < RL3; i++) rd3[i] <= rd3[i-1];
  end

  // bus monitors: record every beat, flag non-idle pins outside beats
  logic [63:0] obs_q[$];
  int idle_bad = 0;
  int acc3 = 0;
  always @(negedge clock) begin
    if (!io_cen) obs_q.push_back({19'h0, io_adr, io_wen, io_wstrb, io_d});
    else if ({io_wen, io_wstrb, io_adr, io_d} !== {1'b1, 4'h0, 8'h0, 32'h0}) idle_bad++;
    if (!d3_io_cen) acc3++;
    else if ({d3_io_wen, d3_io_wstrb, d3_io_adr, d3_io_d} !== {1'b1, 4'h0, 8'h0, 32'h0}) idle_bad++;
  end

  // scoreboard
  logic [31:0] ref_mem [256];
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input int adr, input logic wen,
                                            input logic [3:0] s, input logic [31:0] d);
    logic [7:0] a;
    a = 8'(adr);
    return {19'h0, a, wen, s, d};
  endfunction

  // driver: one request from accept to response handshake; enters and leaves on a negedge
  task automatic do_req(input logic wen, input logic [6:0] idx, input logic [63:0] wdata,
                        input logic [7:0] wstrb, input int stall);
    logic [63:0] exp_data;
    logic [3:0]  s;
    int exp_lat, lat, base;
    base = int'(idx) * 2;
    exp_q.delete();
    if (wen) begin
      exp_lat = 1;
      for (int h = 0; h < 2; h++) begin
        s = wstrb[4*h +: 4];
        if (s != 4'h0) begin
          exp_lat++;
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[base+h][8*b +: 8] = wdata[32*h + 8*b +: 8];
          exp_q.push_back(beat_word(base + h, 1'b0, s, wdata[32*h +: 32]));
        end
      end
      exp_data = 64'h0;
    end else begin
      exp_lat  = 3 + RL1;
      exp_data = {ref_mem[base+1], ref_mem[base]};
      exp_q.push_back(beat_word(base, 1'b1, 4'h0, 32'h0));
      exp_q.push_back(beat_word(base + 1, 1'b1, 4'h0, 32'h0));
    end
    obs_q.delete();
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = idx; req_wdata = wdata; req_wstrb = wstrb;
    resp_ready = (stall == 0);
    @(negedge clock);
    req_valid = 1'b0; req_wen = 1'($urandom); req_addr = 7'($urandom);
    req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("resp_latency", 64'(lat), 64'(exp_lat));
    check("resp_rdata", resp_rdata, exp_data);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_wen = 1'($urandom); req_addr = 7'($urandom); req_wstrb = 8'hFF;
      @(negedge clock);
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_rdata", resp_rdata, exp_data);
      check("stall_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("post_hs_valid", 64'(resp_valid), 64'd0);
    check("beat_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("beat", obs_q[i], exp_q[i]);
  endtask

  int lat3, cnt_bad;
  logic [7:0] rs;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // reset state
    repeat (3) @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'h0);
    check("rst_io_cen", 64'(io_cen), 64'd1);
    reset = 1'b1;
    @(negedge clock);

    // directed cases
    do_req(1'b1, 7'h05, 64'h1122_3344_5566_7788, 8'hFF, 0);
    do_req(1'b0, 7'h05, 64'h0, 8'h00, 0);
    check("rd_known", {ref_mem[11], ref_mem[10]}, 64'h1122_3344_5566_7788);
    do_req(1'b1, 7'h10, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 0);
    do_req(1'b1, 7'h10, 64'h0123_4567_89AB_CDEF, 8'h00, 0);
    do_req(1'b1, 7'h7F, 64'hFEED_FACE_CAFE_F00D, 8'h0F, 0);
    do_req(1'b1, 7'h7F, 64'hFEED_FACE_CAFE_F00D, 8'h3C, 0);
    do_req(1'b0, 7'h7F, 64'h0, 8'h00, 0);
    do_req(1'b0, 7'h10, 64'h0, 8'h00, 5);

    // reset asserted during the HI beat of a read
    obs_q.delete();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 7'h03; resp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("hi_beat_active", 64'(io_cen), 64'd0);
    reset = 1'b0;
    #1;
    check("arst_io_cen", 64'(io_cen), 64'd1);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_resp_rdata", resp_rdata, 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    obs_q.delete();
    cnt_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (resp_valid || !req_ready) cnt_bad++;
    end
    check("no_stale_resp", 64'(cnt_bad), 64'd0);
    check("no_stale_beats", 64'(obs_q.size()), 64'd0);
    resp_ready = 1'b0;

    // random back-to-back mixed traffic
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0:       rs = 8'h00;
        1:       rs = 8'h0F;
        2:       rs = 8'hF0;
        3:       rs = 8'hFF;
        default: rs = 8'($urandom_range(0, 255));
      endcase
      do_req(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), {$urandom, $urandom}, rs,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    // long read latency on the second instance
    acc3 = 0;
    check("d3_req_ready", 64'(d3_req_ready), 64'd1);
    d3_req_valid = 1'b1; d3_req_wen = 1'b0; d3_req_addr = 7'h7F; d3_resp_ready = 1'b1;
    @(negedge clock);
    d3_req_valid = 1'b0;
    lat3 = 1;
    while (!d3_resp_valid && lat3 < 40) begin
      @(negedge clock);
      lat3++;
    end
    check("d3_latency", 64'(lat3), 64'd6);
    check("d3_rdata", d3_resp_rdata, 64'h0000_00FF_0000_00FE);
    @(negedge clock);
    d3_resp_ready = 1'b0;
    check("d3_post_hs_valid", 64'(d3_resp_valid), 64'd0);
    check("d3_beats", 64'(acc3), 64'd2);

    check("idle_pins", 64'(idle_bad), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_master.md
# sram_req_master

Initiator-side controller for the 32-bit single-port `sram_model` array. It accepts one 64-bit load/store request at a time on a valid/ready interface from the rv64 core side. Each request is split into two 32-bit SRAM beats: low word first, then high word. Read words are reassembled and returned on a valid/ready response channel. It drives the SRAM `io_*` pins that the SRAM currently receives from random stimulus.

## Interface
Parameters:
- `ADDR_W`, 8: SRAM word-address width (`io_adr`).
- `READ_LAT`, 1: cycles from a read beat's issue cycle to the cycle `io_q` holds its data; legal range 1..4.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset).
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept.
- `req_wen`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W-1: doubleword index.
- `req_wdata`  in  64: write data.
- `req_wstrb`  in  8: byte strobes; bit i covers byte i.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts response.
- `resp_rdata`  out  64: read data; 0 for writes.
- `io_adr`  out  ADDR_W: SRAM word address.
- `io_cen`  out  1: chip enable, active-low.
- `io_wen`  out  1: write enable, active-low.
- `io_wstrb`  out  4: SRAM byte strobes.
- `io_d`  out  32: SRAM write data.
- `io_q`  in  32: SRAM read data.

## Operation
- FSM states: IDLE, LO, HI, WAIT, RESP.
- `req_ready` = 1 only in IDLE. Only one request is outstanding at a time. On a request handshake, `req_wen`, `req_addr`, `req_wdata` and `req_wstrb` are registered.
- IDLE transitions on accept:
  - A read goes to LO.
  - A write goes to LO if `wstrb[3:0]` ≠ 0.
  - Otherwise a write goes to HI if `wstrb[7:4]` ≠ 0.
  - Otherwise a write goes to RESP.
- LO state drives `io_adr` = {idx,1'b0} and `io_cen` = 0.
  - Write: `io_wen` = 0, `io_wstrb` = `wstrb[3:0]`, `io_d` = `wdata[31:0]`.
  - Read: `io_wen` = 1, `io_wstrb` = 0.
- HI state is the same as LO, but with address {idx,1'b1} and the upper strobe/data halves.
- Write beats whose 4-bit strobe is all zero are skipped: no SRAM access, and no cycle is spent on them.
- LO goes to HI for a read, or for a write with upper strobes nonzero; otherwise LO goes to RESP.
- HI goes to WAIT for a read, or to RESP for a write.
- WAIT lasts exactly READ_LAT cycles, then goes to RESP.
- Read capture uses a READ_LAT-deep tag shift register holding {valid, beat}.
  - `io_q` is sampled into `rdata[31:0]` when the lo tag emerges, and into `rdata[63:32]` when the hi tag emerges.
  - The hi capture occurs in the last WAIT cycle.
- RESP drives `resp_valid` = 1. `resp_rdata` is held stable until `resp_ready`. On the response handshake the FSM goes to IDLE.
- Outside LO/HI, the SRAM pins are at idle values: `io_cen` = 1, `io_wen` = 1, `io_wstrb` = 0, `io_adr` = 0, `io_d` = 0.
- The hi address {idx,1} never carries into idx. Index all-ones accesses words 2^ADDR_W−2 and 2^ADDR_W−1.
- `req_valid` during a non-IDLE state is ignored (`req_ready` = 0). Request inputs may change freely after accept.

## Timing
- C0 is the request-accept cycle.
- Read: C1 = LO, C2 = HI, WAIT is C3..C2+READ_LAT, `resp_valid` first high in C3+READ_LAT. Latency is 4 for READ_LAT = 1.
- Write with both halves enabled: `resp_valid` in C3. With one half enabled: C2. With no strobes: C1.
- Minimum request spacing: the next accept can occur in the cycle after the response handshake, since the FSM is then in IDLE.
- Reset (any state, asynchronous), all immediately:
  - FSM → IDLE and tags cleared.
  - `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0.
  - SRAM pins at idle values.
- No SRAM access is issued during reset, and an interrupted request is dropped with no response.
- All outputs are decoded from registered state only. There is no combinational path from `req_*` or `resp_ready` to the `io_*` outputs.

## Test plan
- Write idx 0x05, data 0x1122334455667788, strobe 0xFF, then read idx 0x05 → one SRAM write each to words 0x0A and 0x0B (`io_d` 0x55667788, then 0x11223344); read response 0x1122334455667788, 4 cycles after accept.
- Write with strobe 0xF0 to idx 0x10 → only word 0x21 is written (`io_wstrb` 0xF); `resp_valid` 2 cycles after accept. Strobe 0x00 → no `io_cen` low at all; `resp_valid` 1 cycle after accept.
- Read with `resp_ready` held 0 for 5 cycles → `resp_valid` and `resp_rdata` stay stable; `req_ready` stays 0; no SRAM access occurs during the stall.
- READ_LAT = 3, SRAM preloaded with word[i] = i, read idx 0x7F → `resp_rdata` = 0x000000FF_000000FE, 6 cycles after accept.
- Drive `reset` low during the HI beat of a read → `io_cen` = 1 and `resp_valid` = 0 immediately; after release, `req_ready` = 1 and no stale response appears.
- Random back-to-back mixed requests checked against a 256×32 reference memory → every response matches and no beat overlaps another request.
